ctrl_decode_pipe: RTL and testbench
===================================

// Module: ctrl_decode_pipe
// PURPOSE
// Parametrised successor to the MIPS-subset decoder: decodes op/funct in ID and
// carries the control word through registered ID/EX, EX/MEM and MEM/WB stages.
// Adds a run/drain/halt FSM replacing the 'inicio' level, stall/flush bubble
// insertion, and illegal-instruction detection with a saturating error counter.
// PARAMETERS
// ALUC_W     4       ALU control width (ADD0 SUB1 AND2 OR3 XOR4 NOR5 SLL6 SRL7 SRA8 SLT9)
// MEMWR_W    4       byte-lane write-enable width (SB 0001, SH 0011, SW 1111)
// DRAIN_CYC  3       cycles in DRAIN after END before halted=1 (>=1)
// ERRCNT_W   8       illegal-instruction counter width
// HALT_OP    6'h3F   opcode of END instruction
// PORTS
// clk          in   1        clock, all state on rising edge
// reset_n      in   1        asynchronous active-low reset
// start        in   1        leave IDLE/HALTED, enter RUN next cycle
// instr_valid  in   1        op/funct hold a real instruction this cycle
// op           in   6        opcode [31:26]
// funct        in   6        funct [5:0]
// stall        in   1        hazard stall: E holds, bubble into M
// flush        in   1        branch flush: bubble into E
// alu_ctrl_e   out  ALUC_W   EX ALU op
// alu_src_e    out  2        0 reg, 1 sign-imm, 2 shamt
// reg_dst_e    out  1        1 rd, 0 rt
// shift_e      out  5        immediate pre-shift (16 for LUI)
// branch_e     out  2        0 none, 1 BEQ, 2 BNE
// mem_write_m  out  MEMWR_W  MEM byte-lane write enable
// mem_read_m   out  2        0 word, 1 byte, 2 half
// mem_unsig_m  out  1        zero-extend load (LBU/LHU/LWU)
// reg_write_w  out  1        WB register write
// mem_to_reg_w out  1        WB select memory data
// running      out  1        FSM in RUN
// halted       out  1        FSM in HALTED
// illegal      out  1        1-cycle pulse, registered, per illegal instruction
// err_count    out  ERRCNT_W saturating count of illegal instructions
// BEHAVIOUR
// Reset: all outputs 0, FSM IDLE, all stage registers hold bubble (all-zero word).
// FSM: IDLE -start-> RUN; RUN -valid END decoded, not stalled/flushed-> DRAIN;
//   DRAIN counts DRAIN_CYC cycles -> HALTED; HALTED -start-> RUN. start ignored in RUN/DRAIN.
// Decode (combinational, valid in RUN only; else bubble): R-type op 0 funct
//   ADD,SUB,AND,OR,XOR,NOR,SLT,SLLV,SRLV,SRAV src0; SLL,SRL,SRA src2; RegWrite,RegDst=1.
//   LB/LH/LW/LBU/LHU/LWU: ADD src1, RegWrite, MemtoReg, mem_read 1/2/0, unsig on U forms.
//   SB/SH/SW: ADD src1, mem_write 0001/0011/1111. ADDI/ANDI/ORI/XORI/SLTI: src1, RegWrite.
//   LUI: SLL src1 shift 16 RegWrite. BEQ/BNE: branch 1/2, no writes. END: bubble.
// Illegal: valid in RUN, op or R-funct not listed -> bubble into E; illegal=1 next
//   cycle; err_count+1, holds at all-ones. Not a state change.
// Pipeline, per edge: E<=(flush|~valid|~RUN)?bubble:(stall?E:decode);
//   M<=stall?bubble:E; W<=M. flush and stall together: E bubble, M bubble.
// Latency: decode->E fields 1 cycle, M fields 2, W fields 3. Fields only from owning stage.
// END under stall is re-decoded when stall drops; END under flush discarded.
// DRAIN: E fed bubbles; M/W drain normally; stall during DRAIN still counts.
// Async reset mid-operation: immediate clear to reset values, incl. err_count.
// TESTING
// reset_n=0 mid-RUN with SW in M -> mem_write_m=0 same cycle, running=0, IDLE.
// IDLE, valid ADD (op0 funct 20h) -> no writes; start, then ADD -> alu_ctrl_e=0
//   at t+1, reg_write_w=1 at t+3.
// RUN: SW then stall=1 one cycle -> mem_write_m=1111 once, then bubble, E held.
// RUN: LHU, flush=1 same cycle -> all E/M/W fields 0; next LUI -> shift_e=16, alu 6.
// op=3Eh valid -> illegal pulse 1 cycle, err_count 1; 300 illegals -> err_count 255.
// END at t -> running=0 at t+1, halted=1 at t+1+DRAIN_CYC; start -> running=1.

Source files
------------

// File: rtl/ctrl_decode_pipe_if.sv
// Bus between the instruction front end and the decode/control pipeline.
// Carries the instruction, the hazard controls, the stage-owned control fields and the FSM status.
interface ctrl_decode_pipe_if #(
    parameter int ALUC_W   = 4,
    parameter int MEMWR_W  = 4,
    parameter int ERRCNT_W = 8
);
    // Handshake: op/funct are meaningful only in a cycle where instr_valid=1 and the FSM is in RUN.
    // The instruction is consumed on the next rising edge unless stall or flush is high in that cycle.
    // When stall is high, the source must hold the same instruction and keep instr_valid high.
    // When flush is high, the instruction is discarded.
    // No ready signal exists; stall is the only back-pressure.
    logic                start;
    logic                instr_valid;
    logic [5:0]          op;
    logic [5:0]          funct;
    logic                stall;
    logic                flush;
    logic [ALUC_W-1:0]   alu_ctrl_e;
    logic [1:0]          alu_src_e;
    logic                reg_dst_e;
    logic [4:0]          shift_e;
    logic [1:0]          branch_e;
    logic [MEMWR_W-1:0]  mem_write_m;
    logic [1:0]          mem_read_m;
    logic                mem_unsig_m;
    logic                reg_write_w;
    logic                mem_to_reg_w;
    logic                running;
    logic                halted;
    logic                illegal;
    logic [ERRCNT_W-1:0] err_count;
    logic [1:0]          dbg_state;

    modport master (
        output start, instr_valid, op, funct, stall, flush,
        input  alu_ctrl_e, alu_src_e, reg_dst_e, shift_e, branch_e,
        input  mem_write_m, mem_read_m, mem_unsig_m, reg_write_w, mem_to_reg_w,
        input  running, halted, illegal, err_count, dbg_state
    );

    modport slave (
        input  start, instr_valid, op, funct, stall, flush,
        output alu_ctrl_e, alu_src_e, reg_dst_e, shift_e, branch_e,
        output mem_write_m, mem_read_m, mem_unsig_m, reg_write_w, mem_to_reg_w,
        output running, halted, illegal, err_count, dbg_state
    );
endinterface

// File: rtl/ctrl_decode_pipe.sv
// MIPS-subset control decoder with registered ID/EX, EX/MEM and MEM/WB control stages.
// A run/drain/halt FSM gates decoding, and illegal instructions are counted with saturation.
module ctrl_decode_pipe #(
    parameter int          ALUC_W    = 4,
    parameter int          MEMWR_W   = 4,
    parameter int          DRAIN_CYC = 3,
    parameter int          ERRCNT_W  = 8,
    parameter logic [5:0]  HALT_OP   = 6'h3F
) (
    input  logic            clk,
    input  logic            reset_n,
    ctrl_decode_pipe_if.slave bus
);
    localparam int CNT_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

    typedef struct packed {
        logic [ALUC_W-1:0]  alu_ctrl;
        logic [1:0]         alu_src;
        logic               reg_dst;
        logic [4:0]         shift;
        logic [1:0]         branch;
        logic [MEMWR_W-1:0] mem_write;
        logic [1:0]         mem_read;
        logic               mem_unsig;
        logic               reg_write;
        logic               mem_to_reg;
    } ctrl_t;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_HALTED} state_t;

    localparam ctrl_t BUBBLE = '0;

    localparam logic [ALUC_W-1:0] ALU_ADD = ALUC_W'(0);
    localparam logic [ALUC_W-1:0] ALU_SUB = ALUC_W'(1);
    localparam logic [ALUC_W-1:0] ALU_AND = ALUC_W'(2);
    localparam logic [ALUC_W-1:0] ALU_OR  = ALUC_W'(3);
    localparam logic [ALUC_W-1:0] ALU_XOR = ALUC_W'(4);
    localparam logic [ALUC_W-1:0] ALU_NOR = ALUC_W'(5);
    localparam logic [ALUC_W-1:0] ALU_SLL = ALUC_W'(6);
    localparam logic [ALUC_W-1:0] ALU_SRL = ALUC_W'(7);
    localparam logic [ALUC_W-1:0] ALU_SRA = ALUC_W'(8);
    localparam logic [ALUC_W-1:0] ALU_SLT = ALUC_W'(9);

    state_t              state_q;
    logic [CNT_W-1:0]    drain_cnt_q;
    logic                running_q, halted_q;
    ctrl_t               e_q, m_q, w_q, e_d, m_d, w_d, dec_d;
    logic                known, is_end, run, take;
    logic                illegal_q, illegal_d;
    logic [ERRCNT_W-1:0] err_q, err_d;

    always_comb begin
        dec_d  = BUBBLE;
        known  = 1'b1;
        is_end = 1'b0;
        case (bus.op)
            6'h00: begin
                dec_d.reg_write = 1'b1;
                dec_d.reg_dst   = 1'b1;
                case (bus.funct)
                    6'h20: dec_d.alu_ctrl = ALU_ADD;
                    6'h22: dec_d.alu_ctrl = ALU_SUB;
                    6'h24: dec_d.alu_ctrl = ALU_AND;
                    6'h25: dec_d.alu_ctrl = ALU_OR;
                    6'h26: dec_d.alu_ctrl = ALU_XOR;
                    6'h27: dec_d.alu_ctrl = ALU_NOR;
                    6'h2A: dec_d.alu_ctrl = ALU_SLT;
                    6'h04: dec_d.alu_ctrl = ALU_SLL;
                    6'h06: dec_d.alu_ctrl = ALU_SRL;
                    6'h07: dec_d.alu_ctrl = ALU_SRA;
                    6'h00: begin dec_d.alu_ctrl = ALU_SLL; dec_d.alu_src = 2'd2; end
                    6'h02: begin dec_d.alu_ctrl = ALU_SRL; dec_d.alu_src = 2'd2; end
                    6'h03: begin dec_d.alu_ctrl = ALU_SRA; dec_d.alu_src = 2'd2; end
                    default: known = 1'b0;
                endcase
            end
            6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h27: begin
                dec_d.alu_src    = 2'd1;
                dec_d.reg_write  = 1'b1;
                dec_d.mem_to_reg = 1'b1;
                dec_d.mem_read   = (bus.op[1:0] == 2'b00) ? 2'd1 :
                                   (bus.op[1:0] == 2'b01) ? 2'd2 : 2'd0;
                dec_d.mem_unsig  = (bus.op == 6'h24) || (bus.op == 6'h25) || (bus.op == 6'h27);
            end
            6'h28: begin dec_d.alu_src = 2'd1; dec_d.mem_write = MEMWR_W'(4'b0001); end
            6'h29: begin dec_d.alu_src = 2'd1; dec_d.mem_write = MEMWR_W'(4'b0011); end
            6'h2B: begin dec_d.alu_src = 2'd1; dec_d.mem_write = MEMWR_W'(4'b1111); end
            6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h0E: begin
                dec_d.alu_src   = 2'd1;
                dec_d.reg_write = 1'b1;
                case (bus.op)
                    6'h0A:   dec_d.alu_ctrl = ALU_SLT;
                    6'h0C:   dec_d.alu_ctrl = ALU_AND;
                    6'h0D:   dec_d.alu_ctrl = ALU_OR;
                    6'h0E:   dec_d.alu_ctrl = ALU_XOR;
                    default: dec_d.alu_ctrl = ALU_ADD;
                endcase
            end
            6'h0F: begin
                dec_d.alu_ctrl  = ALU_SLL;
                dec_d.alu_src   = 2'd1;
                dec_d.shift     = 5'd16;
                dec_d.reg_write = 1'b1;
            end
            // Branches compare by subtraction and write nothing.
            6'h04: begin dec_d.alu_ctrl = ALU_SUB; dec_d.branch = 2'd1; end
            6'h05: begin dec_d.alu_ctrl = ALU_SUB; dec_d.branch = 2'd2; end
            HALT_OP: is_end = 1'b1;
            default: known = 1'b0;
        endcase
        if (!known || is_end) dec_d = BUBBLE;
    end

    always_comb begin
        run  = (state_q == S_RUN);
        // A stalled instruction is re-presented later and a flushed one is dropped, so neither is consumed now.
        take = run && bus.instr_valid && !bus.flush && !bus.stall;
        if (bus.flush || !bus.instr_valid || !run) e_d = BUBBLE;
        else if (bus.stall)                        e_d = e_q;
        else                                       e_d = dec_d;
        m_d       = bus.stall ? BUBBLE : e_q;
        w_d       = m_q;
        illegal_d = take && !known;
        err_d     = (illegal_d && (err_q != {ERRCNT_W{1'b1}})) ? err_q + 1'b1 : err_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            e_q       <= BUBBLE;
            m_q       <= BUBBLE;
            w_q       <= BUBBLE;
            illegal_q <= 1'b0;
            err_q     <= '0;
        end else begin
            e_q       <= e_d;
            m_q       <= m_d;
            w_q       <= w_d;
            illegal_q <= illegal_d;
            err_q     <= err_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            drain_cnt_q <= '0;
            running_q   <= 1'b0;
            halted_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_HALTED: if (bus.start) begin
                    state_q   <= S_RUN;
                    running_q <= 1'b1;
                    halted_q  <= 1'b0;
                end
                S_RUN: if (take && is_end) begin
                    state_q     <= S_DRAIN;
                    drain_cnt_q <= '0;
                    running_q   <= 1'b0;
                end
                S_DRAIN: begin
                    if (drain_cnt_q == CNT_W'(DRAIN_CYC - 1)) begin
                        state_q  <= S_HALTED;
                        halted_q <= 1'b1;
                    end else begin
                        drain_cnt_q <= drain_cnt_q + 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.alu_ctrl_e   = e_q.alu_ctrl;
    assign bus.alu_src_e    = e_q.alu_src;
    assign bus.reg_dst_e    = e_q.reg_dst;
    assign bus.shift_e      = e_q.shift;
    assign bus.branch_e     = e_q.branch;
    assign bus.mem_write_m  = m_q.mem_write;
    assign bus.mem_read_m   = m_q.mem_read;
    assign bus.mem_unsig_m  = m_q.mem_unsig;
    assign bus.reg_write_w  = w_q.reg_write;
    assign bus.mem_to_reg_w = w_q.mem_to_reg;
    assign bus.running      = running_q;
    assign bus.halted       = halted_q;
    assign bus.illegal      = illegal_q;
    assign bus.err_count    = err_q;
    assign bus.dbg_state    = state_q;
endmodule

// File: tb/tb_ctrl_decode_pipe.sv
// Directed bench for ctrl_decode_pipe: decode fields, stage latency, stall/flush bubbles,
// illegal counting, END drain/halt and asynchronous reset.
module tb_ctrl_decode_pipe;
  logic clk;
  logic reset_n;
  int   n_checks;
  int   n_errors;
  logic [5:0] exp_q[$];

  ctrl_decode_pipe_if #(.ALUC_W(4), .MEMWR_W(4), .ERRCNT_W(8)) bus ();

  ctrl_decode_pipe #(
    .ALUC_W(4), .MEMWR_W(4), .DRAIN_CYC(3), .ERRCNT_W(8), .HALT_OP(6'h3F)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got timeout required finish");
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors + 1);
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic drive(input logic v, input logic [5:0] o, input logic [5:0] f,
                       input logic s, input logic fl);
    bus.instr_valid = v;
    bus.op          = o;
    bus.funct       = f;
    bus.stall       = s;
    bus.flush       = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    drive(1'b0, 6'h00, 6'h00, 1'b0, 1'b0);
  endtask

  logic [5:0] r_funct [6];
  logic [5:0] r_exp   [6];

  initial begin
    n_checks = 0;
    n_errors = 0;
    r_funct = '{6'h22, 6'h24, 6'h27, 6'h00, 6'h07, 6'h2A};
    r_exp   = '{6'h01, 6'h02, 6'h05, 6'h26, 6'h08, 6'h09};
    reset_n   = 1'b0;
    bus.start = 1'b0;
    idle_in();
    #1;
    check_eq("rst_running", bus.running, 0);
    check_eq("rst_halted", bus.halted, 0);
    check_eq("rst_state", bus.dbg_state, 0);
    check_eq("rst_memwr", bus.mem_write_m, 0);
    check_eq("rst_regwr", bus.reg_write_w, 0);
    check_eq("rst_err", bus.err_count, 0);
    tick();
    tick();
    reset_n = 1'b1;

    // IDLE ignores instructions
    drive(1'b1, 6'h00, 6'h20, 1'b0, 1'b0);
    tick();
    check_eq("idle_regdst", bus.reg_dst_e, 0);
    tick();
    tick();
    check_eq("idle_regwr", bus.reg_write_w, 0);
    check_eq("idle_running", bus.running, 0);

    idle_in();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check_eq("start_running", bus.running, 1);
    check_eq("start_state", bus.dbg_state, 1);

    // ADD latency: E at +1, W at +3
    drive(1'b1, 6'h00, 6'h20, 1'b0, 1'b0);
    tick();
    check_eq("add_alu_e", bus.alu_ctrl_e, 0);
    check_eq("add_regdst_e", bus.reg_dst_e, 1);
    idle_in();
    tick();
    check_eq("add_e_bubble", bus.reg_dst_e, 0);
    check_eq("add_regwr_m", bus.reg_write_w, 0);
    tick();
    check_eq("add_regwr_w", bus.reg_write_w, 1);
    tick();
    check_eq("add_regwr_clr", bus.reg_write_w, 0);

    // back-to-back R-types
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 6'h00, r_funct[i], 1'b0, 1'b0);
      exp_q.push_back(r_exp[i]);
      tick();
      check_eq("rtype_src_alu", {bus.alu_src_e, bus.alu_ctrl_e}, exp_q.pop_front());
      check_eq("rtype_illegal", bus.illegal, 0);
    end
    idle_in();
    tick();

    // SW then a one-cycle stall
    drive(1'b1, 6'h2B, 6'h00, 1'b0, 1'b0);
    tick();
    check_eq("sw_src_e", bus.alu_src_e, 1);
    drive(1'b1, 6'h08, 6'h00, 1'b1, 1'b0);
    tick();
    check_eq("stall_e_held_src", bus.alu_src_e, 1);
    check_eq("stall_m_bubble", bus.mem_write_m, 0);
    drive(1'b1, 6'h08, 6'h00, 1'b0, 1'b0);
    tick();
    check_eq("sw_memwr_m", bus.mem_write_m, 4'hF);
    idle_in();
    tick();
    check_eq("sw_memwr_once", bus.mem_write_m, 0);
    check_eq("sw_regwr_w", bus.reg_write_w, 0);
    tick();
    check_eq("addi_regwr_w", bus.reg_write_w, 1);

    // LHU flushed, then LUI, then LHU
    drive(1'b1, 6'h25, 6'h00, 1'b0, 1'b1);
    tick();
    check_eq("flush_src_e", bus.alu_src_e, 0);
    drive(1'b1, 6'h0F, 6'h00, 1'b0, 1'b0);
    tick();
    check_eq("lui_shift_e", bus.shift_e, 16);
    check_eq("lui_alu_e", bus.alu_ctrl_e, 6);
    check_eq("flush_memrd_m", bus.mem_read_m, 0);
    check_eq("flush_unsig_m", bus.mem_unsig_m, 0);
    drive(1'b1, 6'h25, 6'h00, 1'b0, 1'b0);
    tick();
    check_eq("flush_regwr_w", bus.reg_write_w, 0);
    check_eq("flush_m2r_w", bus.mem_to_reg_w, 0);
    idle_in();
    tick();
    check_eq("lhu_memrd_m", bus.mem_read_m, 2);
    check_eq("lhu_unsig_m", bus.mem_unsig_m, 1);
    check_eq("lui_regwr_w", bus.reg_write_w, 1);
    tick();
    check_eq("lhu_m2r_w", bus.mem_to_reg_w, 1);

    // BNE and SB
    drive(1'b1, 6'h05, 6'h00, 1'b0, 1'b0);
    tick();
    check_eq("bne_branch_e", bus.branch_e, 2);
    drive(1'b1, 6'h28, 6'h00, 1'b0, 1'b0);
    tick();
    check_eq("sb_branch_clr", bus.branch_e, 0);
    idle_in();
    tick();
    check_eq("sb_memwr_m", bus.mem_write_m, 4'h1);

    // illegal opcode and illegal funct
    drive(1'b1, 6'h3E, 6'h00, 1'b0, 1'b0);
    tick();
    check_eq("ill_pulse", bus.illegal, 1);
    check_eq("ill_cnt1", bus.err_count, 1);
    check_eq("ill_running", bus.running, 1);
    idle_in();
    tick();
    check_eq("ill_pulse_end", bus.illegal, 0);
    drive(1'b1, 6'h00, 6'h01, 1'b0, 1'b0);
    tick();
    check_eq("ill_funct", bus.illegal, 1);
    check_eq("ill_cnt2", bus.err_count, 2);
    check_eq("ill_funct_e", bus.reg_dst_e, 0);
    drive(1'b1, 6'h3E, 6'h00, 1'b0, 1'b0);
    for (int i = 0; i < 300; i++) tick();
    idle_in();
    tick();
    check_eq("ill_sat", bus.err_count, 8'hFF);

    // END under flush, END under stall, then END taken
    drive(1'b1, 6'h3F, 6'h00, 1'b0, 1'b1);
    tick();
    check_eq("end_flush_run", bus.running, 1);
    drive(1'b1, 6'h3F, 6'h00, 1'b1, 1'b0);
    tick();
    check_eq("end_stall_run", bus.running, 1);
    drive(1'b1, 6'h3F, 6'h00, 1'b0, 1'b0);
    tick();
    check_eq("end_running", bus.running, 0);
    check_eq("end_state", bus.dbg_state, 2);
    drive(1'b0, 6'h00, 6'h00, 1'b1, 1'b0);
    tick();
    tick();
    check_eq("drain_halted", bus.halted, 0);
    tick();
    check_eq("halted", bus.halted, 1);
    idle_in();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check_eq("restart_running", bus.running, 1);
    check_eq("restart_halted", bus.halted, 0);

    // asynchronous reset with SW in M
    drive(1'b1, 6'h2B, 6'h00, 1'b0, 1'b0);
    tick();
    idle_in();
    tick();
    check_eq("ar_memwr_pre", bus.mem_write_m, 4'hF);
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("ar_memwr", bus.mem_write_m, 0);
    check_eq("ar_running", bus.running, 0);
    check_eq("ar_state", bus.dbg_state, 0);
    check_eq("ar_err", bus.err_count, 0);
    tick();
    reset_n = 1'b1;
    tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
